// File: rtl/control_fsm.sv
// Multicycle main control unit: steps lw/sw/R-type/beq through fetch..writeback,
// drives datapath enables, mux selects and ALUOp, and faults on bad opcodes or memory stalls.
module control_fsm #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instrucao,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        adr_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [1:0]  ALUOp,
   output logic        branch,
   output logic        fault,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECR    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_FAULT    = 4'd10
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] alu_op;
      logic       branch;
      logic       fault;
   } ctrl_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam int              CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   WAIT_MAX  = CW'(TIMEOUT);

   state_t        cur_state, nxt_state;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic [6:0]    opcode;
   logic          in_wait;
   logic          timed_out;
   ctrl_t         ctrl;
   logic          unused_instr_bits;

   assign opcode            = instrucao[6:0];
   assign unused_instr_bits = ^instrucao[31:7];

   assign in_wait   = (cur_state == S_FETCH) || (cur_state == S_MEMREAD) ||
                      (cur_state == S_MEMWRITE);
   // A completing access on the last allowed cycle still wins over the timeout.
   assign timed_out = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_RESET:    nxt_state = S_FETCH;
         S_FETCH:    if (mem_ready) nxt_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_R:         nxt_state = S_EXECR;
               OP_BEQ:       nxt_state = S_BEQ;
               default:      nxt_state = S_FAULT;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      nxt_state = S_MEMREAD;
            else if (opcode == OP_SW) nxt_state = S_MEMWRITE;
            else                      nxt_state = S_FAULT;
         end
         S_MEMREAD:  if (mem_ready) nxt_state = S_MEMWB;
         S_MEMWRITE: if (mem_ready) nxt_state = S_FETCH;
         S_EXECR:    nxt_state = S_ALUWB;
         S_MEMWB,
         S_ALUWB,
         S_BEQ:      nxt_state = S_FETCH;
         S_FAULT:    nxt_state = S_FAULT;
         default:    nxt_state = S_FAULT;
      endcase
      if (timed_out) nxt_state = S_FAULT;
   end

   // Any state change clears the count, so each wait state starts from zero on entry.
   always_comb begin
      wait_cnt_nxt = wait_cnt;
      if (nxt_state != cur_state)
         wait_cnt_nxt = '0;
      else if (in_wait && !mem_ready && (wait_cnt != WAIT_MAX))
         wait_cnt_nxt = wait_cnt + CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= S_RESET;
         wait_cnt  <= '0;
      end else begin
         cur_state <= nxt_state;
         wait_cnt  <= wait_cnt_nxt;
      end
   end

   always_comb begin
      ctrl = '0;
      case (cur_state)
         S_FETCH: begin
            ctrl.mem_read   = 1'b1;
            ctrl.alu_src_b  = 2'b10;
            ctrl.result_src = 2'b10;
            ctrl.ir_write   = mem_ready;
            ctrl.pc_write   = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = 2'b01;
            ctrl.alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 2'b10;
            ctrl.alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            ctrl.mem_read = 1'b1;
            ctrl.adr_src  = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = 2'b01;
         end
         S_MEMWRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.adr_src   = 1'b1;
         end
         S_EXECR: begin
            ctrl.alu_src_a = 2'b10;
            ctrl.alu_op    = 2'b10;
         end
         S_ALUWB:  ctrl.reg_write = 1'b1;
         S_BEQ: begin
            ctrl.alu_src_a = 2'b10;
            ctrl.alu_op    = 2'b01;
            ctrl.branch    = 1'b1;
         end
         S_FAULT:  ctrl.fault = 1'b1;
         default:  ctrl = '0;
      endcase
   end

   assign pc_write   = ctrl.pc_write;
   assign ir_write   = ctrl.ir_write;
   assign mem_read   = ctrl.mem_read;
   assign mem_write  = ctrl.mem_write;
   assign reg_write  = ctrl.reg_write;
   assign adr_src    = ctrl.adr_src;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign result_src = ctrl.result_src;
   assign ALUOp      = ctrl.alu_op;
   assign branch     = ctrl.branch;
   assign fault      = ctrl.fault;
   assign state      = cur_state;

endmodule
